// File: rtl/edulent_pkg.sv
// edulent_pkg: shared types for the Edulent memory arbiter
package edulent_pkg;

    typedef enum logic [1:0] {SHARED, DRAIN, LOCKED} arb_state_t;
    typedef enum logic {OWN_CORE, OWN_LDR} arb_owner_t;

endpackage

// File: rtl/edulent_mem_arbiter.sv
// edulent_mem_arbiter: single-port memory arbiter between core and loader with starvation guard and bus lock
module edulent_mem_arbiter
    import edulent_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_gnt,
    output logic              o_core_stall,
    output logic              o_core_rvalid,
    output logic [DATA_W-1:0] o_core_rdata,
    input  logic              i_ldr_req,
    input  logic              i_ldr_we,
    input  logic [ADDR_W-1:0] i_ldr_addr,
    input  logic [DATA_W-1:0] i_ldr_wdata,
    input  logic              i_ldr_lock,
    output logic              o_ldr_gnt,
    output logic              o_ldr_locked,
    output logic              o_ldr_rvalid,
    output logic [DATA_W-1:0] o_ldr_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t state, state_d;
    arb_owner_t rd_owner;
    logic       rd_pend;
    logic       rd_gnt;
    logic [3:0] starve_cnt;

    // Pick the winner for this cycle and steer its request onto the memory port
    always_comb begin
        o_core_gnt   = (state == SHARED) & i_core_req & (~i_ldr_req | (starve_cnt < STARVE_LIM));
        o_ldr_gnt    = i_ldr_req & ~o_core_gnt & ((state == SHARED) | (state == LOCKED));
        o_mem_en     = o_core_gnt | o_ldr_gnt;
        o_mem_we     = o_core_gnt ? i_core_we : (o_ldr_gnt & i_ldr_we);
        o_mem_addr   = o_core_gnt ? i_core_addr : o_ldr_gnt ? i_ldr_addr : '0;
        o_mem_wdata  = o_core_gnt ? i_core_wdata : o_ldr_gnt ? i_ldr_wdata : '0;
        o_core_stall = i_core_req & ~o_core_gnt;
        rd_gnt       = o_mem_en & ~o_mem_we;
    end

    // Lock sequencing; DRAIN waits until no read is left outstanding past this edge
    always_comb begin
        state_d = state;
        case (state)
            SHARED:  state_d = i_ldr_lock ? DRAIN : SHARED;
            DRAIN:   state_d = ~i_ldr_lock ? SHARED : rd_gnt ? DRAIN : LOCKED;
            LOCKED:  state_d = i_ldr_lock ? LOCKED : SHARED;
            default: state_d = SHARED;
        endcase
    end

    // State, starvation counter and read-return tracking
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= SHARED;
            starve_cnt <= '0;
            rd_pend    <= 1'b0;
            rd_owner   <= OWN_CORE;
        end else begin
            state      <= state_d;
            starve_cnt <= ((state == LOCKED) | o_ldr_gnt | ~i_ldr_req) ? 4'd0 :
                          (o_core_gnt & (starve_cnt != STARVE_LIM)) ? starve_cnt + 4'd1 : starve_cnt;
            rd_pend    <= rd_gnt;
            rd_owner   <= o_ldr_gnt ? OWN_LDR : OWN_CORE;
        end
    end

    assign o_core_rvalid = rd_pend & (rd_owner == OWN_CORE);
    assign o_ldr_rvalid  = rd_pend & (rd_owner == OWN_LDR);
    assign o_core_rdata  = o_core_rvalid ? i_mem_rdata : '0;
    assign o_ldr_rdata   = o_ldr_rvalid ? i_mem_rdata : '0;
    assign o_ldr_locked  = (state == LOCKED) | ((state == DRAIN) & ~rd_pend & i_ldr_lock);

endmodule
